systolic_output_collector: RTL and testbench

- Sits directly downstream of the 4x4 systolic array and consumes its bottom-row psums and valids.
- Column j output arrives j-1 cycles after column 1, so the collector deskews the columns into aligned result rows.
- Aligned rows are buffered in a small FIFO and handed to the unified-buffer write port over a valid/ready handshake.
- Flags when the expected row count has been delivered, and flags skew and overflow faults.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/systolic_output_collector.sv | 195 +++++++++++++++++++
 tb/tb_systolic_output_collector.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic array output path.
package systolic_pkg;

  localparam int DEFAULT_SYSTOLIC_ARRAY_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH           = 16;
  localparam int DEFAULT_FIFO_DEPTH           = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } collector_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when
// a pop in the same cycle frees the slot.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/systolic_output_collector.sv
// Deskews the bottom-row psums of the systolic array into aligned rows, buffers
// them and hands them to the unified buffer over a valid/ready handshake.
module systolic_output_collector
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = DEFAULT_SYSTOLIC_ARRAY_WIDTH,
  parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH           = DEFAULT_FIFO_DEPTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] col_data_in,
  input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]            col_valid_in,
  input  logic [15:0]                                cfg_col_size_in,
  input  logic                                       cfg_col_size_valid_in,
  input  logic [15:0]                                cfg_row_count_in,
  input  logic                                       cfg_start,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] out_row_data,
  output logic                                       out_row_valid,
  input  logic                                       out_row_ready,
  output logic                                       out_row_last,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       skew_err,
  output logic                                       overflow_err
);

  localparam int N  = SYSTOLIC_ARRAY_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int RW = N * DW;

  logic [N-1:0]     col_mask_reg;
  logic [N-1:0]     col_mask_next;
  logic [N-1:0]     dsk_valid;
  logic [RW-1:0]    dsk_data;
  logic [RW-1:0]    row_data;

  collector_state_t state_reg;
  logic [15:0]      row_target_reg;
  logic [15:0]      rows_in_reg;
  logic [15:0]      rows_out_reg;
  logic             skew_err_reg;
  logic             overflow_err_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             row_event;
  logic             row_drop;
  logic             skew_hit;

  // Column size saturates: any size >= N enables every column.
  always_comb begin
    col_mask_next = '0;
    for (int j = 0; j < N; j++) begin
      col_mask_next[j] = (cfg_col_size_in > 16'(j));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_mask_reg <= '0;
    end else if (cfg_col_size_valid_in) begin
      col_mask_reg <= col_mask_next;
    end
  end

  // Column gi arrives gi cycles late, so it is delayed by the remaining N-1-gi cycles.
  for (genvar gi = 0; gi < N; gi++) begin : g_col
    localparam int DLY = N - 1 - gi;
    if (DLY == 0) begin : g_direct
      assign dsk_valid[gi]           = col_valid_in[gi];
      assign dsk_data[gi*DW +: DW]   = col_data_in[gi*DW +: DW];
    end else begin : g_delay
      logic [DLY-1:0] valid_pipe_reg;
      logic [DW-1:0]  data_pipe_reg [DLY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_pipe_reg <= '0;
          for (int k = 0; k < DLY; k++) begin
            data_pipe_reg[k] <= '0;
          end
        end else begin
          valid_pipe_reg[0] <= col_valid_in[gi];
          data_pipe_reg[0]  <= col_data_in[gi*DW +: DW];
          for (int k = 1; k < DLY; k++) begin
            valid_pipe_reg[k] <= valid_pipe_reg[k-1];
            data_pipe_reg[k]  <= data_pipe_reg[k-1];
          end
        end
      end

      assign dsk_valid[gi]         = valid_pipe_reg[DLY-1];
      assign dsk_data[gi*DW +: DW] = data_pipe_reg[DLY-1];
    end

    assign row_data[gi*DW +: DW] = col_mask_reg[gi] ? dsk_data[gi*DW +: DW] : '0;
  end

  assign row_event = (state_reg == COLLECT) && dsk_valid[0];
  assign fifo_pop  = !fifo_empty && out_row_ready;
  assign row_drop  = row_event && fifo_full && !fifo_pop;
  assign skew_hit  = (state_reg == COLLECT) &&
                     (dsk_valid[0] ? |(col_mask_reg & ~dsk_valid)
                                   : |(col_mask_reg & dsk_valid));

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (row_event),
    .push_data (row_data),
    .pop       (fifo_pop),
    .pop_data  (out_row_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      row_target_reg   <= '0;
      rows_in_reg      <= '0;
      rows_out_reg     <= '0;
      skew_err_reg     <= 1'b0;
      overflow_err_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (fifo_pop) begin
        rows_out_reg <= rows_out_reg + 16'd1;
      end
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            row_target_reg   <= cfg_row_count_in;
            rows_in_reg      <= '0;
            rows_out_reg     <= '0;
            skew_err_reg     <= 1'b0;
            overflow_err_reg <= 1'b0;
            if (cfg_row_count_in == 16'd0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= COLLECT;
              busy_reg  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (skew_hit) begin
            skew_err_reg <= 1'b1;
          end
          if (row_drop) begin
            overflow_err_reg <= 1'b1;
          end
          if (row_event) begin
            rows_in_reg <= rows_in_reg + 16'd1;
            if (rows_in_reg + 16'd1 == row_target_reg) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Dropped rows mean the last row never reaches the output, so finish on empty.
          if ((fifo_pop && out_row_last) || (overflow_err_reg && fifo_empty)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_row_valid = !fifo_empty;
  assign out_row_last  = out_row_valid && (rows_out_reg == row_target_reg - 16'd1);
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign skew_err      = skew_err_reg;
  assign overflow_err  = overflow_err_reg;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Self-checking bench for systolic_output_collector: vector table, directed
// corner sequences and randomized jobs against a row-queue reference.
module tb_systolic_output_collector;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [63:0]   col_data_in;
  logic [3:0]    col_valid_in;
  logic [15:0]   cfg_col_size_in;
  logic          cfg_col_size_valid_in;
  logic [15:0]   cfg_row_count_in;
  logic          cfg_start;
  logic [63:0]   out_row_data;
  logic          out_row_valid;
  logic          out_row_ready;
  logic          out_row_last;
  logic          busy;
  logic          done;
  logic          skew_err;
  logic          overflow_err;

  systolic_output_collector dut (
    .clk                   (clk),
    .rst                   (rst),
    .col_data_in           (col_data_in),
    .col_valid_in          (col_valid_in),
    .cfg_col_size_in       (cfg_col_size_in),
    .cfg_col_size_valid_in (cfg_col_size_valid_in),
    .cfg_row_count_in      (cfg_row_count_in),
    .cfg_start             (cfg_start),
    .out_row_data          (out_row_data),
    .out_row_valid         (out_row_valid),
    .out_row_ready         (out_row_ready),
    .out_row_last          (out_row_last),
    .busy                  (busy),
    .done                  (done),
    .skew_err              (skew_err),
    .overflow_err          (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] size;
    logic [63:0] data;
    logic [3:0]  vld;
    logic [63:0] exp_row;
    logic        exp_skew;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pop_idx = 0;
  int          job_target = 0;
  bit          expect_last = 1'b1;
  int          last_pop_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  bit          ready_rand = 1'b0;
  int          ready_hook = -1;
  logic [63:0] exp_q [$];
  logic [63:0] rd [16];
  logic [3:0]  rv [16];
  bit          valid_trace [64];
  vec_t        vecs [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must deliver the next queued row, last only on the final one.
  always @(negedge clk) begin
    if (rst && out_row_valid && out_row_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got row %h, required no row", out_row_data);
      end else begin
        check("row_data", out_row_data, exp_q.pop_front());
      end
      check("row_last", 64'(out_row_last), 64'(expect_last && (pop_idx == job_target - 1)));
      pop_idx++;
      last_pop_cyc = cyc;
    end
    if (rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    if (ready_rand) out_row_ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] size, input logic [15:0] rows);
    cfg_col_size_in       = size;
    cfg_col_size_valid_in = 1'b1;
    tick();
    cfg_col_size_valid_in = 1'b0;
    cfg_row_count_in      = rows;
    cfg_start             = 1'b1;
    job_target            = int'(rows);
    pop_idx               = 0;
    expect_last           = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Row r enters column j at cycle r*gap + j, modelling the array's column skew.
  task automatic play_rows(input int n, input int gap);
    int last_c;
    last_c = (n - 1) * gap + N - 1;
    for (int c = 0; c <= last_c; c++) begin
      for (int j = 0; j < N; j++) begin
        int r;
        r = c - j;
        col_valid_in[j]         = 1'b0;
        col_data_in[j*16 +: 16] = 16'($urandom);
        if (r >= 0 && (r % gap) == 0 && (r / gap) < n) begin
          col_valid_in[j]         = rv[r/gap][j];
          col_data_in[j*16 +: 16] = rd[r/gap][j*16 +: 16];
        end
      end
      if (c == ready_hook) out_row_ready = 1'b1;
      else if (ready_hook >= 0) out_row_ready = 1'b0;
      valid_trace[c] = out_row_valid;
      tick();
    end
    col_valid_in = '0;
  endtask

  task automatic wait_done(input string name, input int exp_delay);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < 200) begin
      tick();
      k++;
    end
    tests++;
    if (done_cnt == n0) begin
      fails++;
      $display("FAIL %s_done_timeout: got no done pulse in 200 cycles, required one", name);
    end else begin
      if (exp_delay >= 0)
        check({name, "_done_delay"}, 64'(done_cyc - last_pop_cyc), 64'(exp_delay));
      check({name, "_done_one_cycle"}, 64'(done), 64'd0);
      check({name, "_busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  function automatic logic [63:0] model_row(input logic [63:0] data, input int size);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (j < size) r[j*16 +: 16] = data[j*16 +: 16];
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd4, 64'h0004_0003_0002_0001, 4'b1111, 64'h0004_0003_0002_0001, 1'b0};
    vecs[1] = '{16'd2, 64'hAAAA_AAAA_AAAA_AAAA, 4'b1111, 64'h0000_0000_AAAA_AAAA, 1'b0};
    vecs[2] = '{16'd4, 64'h0044_0033_0022_0011, 4'b1011, 64'h0044_0033_0022_0011, 1'b1};
    vecs[3] = '{16'd1, 64'h4444_3333_2222_1234, 4'b0001, 64'h0000_0000_0000_1234, 1'b0};
    vecs[4] = '{16'd9, 64'hDEAD_BEEF_CAFE_F00D, 4'b1111, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[5] = '{16'd0, 64'h1111_2222_3333_4444, 4'b0001, 64'h0000_0000_0000_0000, 1'b0};
    vecs[6] = '{16'd3, 64'hFFFF_0C0C_0B0B_0A0A, 4'b0111, 64'h0000_0C0C_0B0B_0A0A, 1'b0};
    vecs[7] = '{16'd4, 64'h0004_0003_0002_0001, 4'b0111, 64'h0004_0003_0002_0001, 1'b1};

    rst = 1'b0;
    col_data_in = '0;
    col_valid_in = '0;
    cfg_col_size_in = '0;
    cfg_col_size_valid_in = 1'b0;
    cfg_row_count_in = '0;
    cfg_start = 1'b0;
    out_row_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(out_row_valid), 64'd0);
    check("rst_last", 64'(out_row_last), 64'd0);
    check("rst_data", out_row_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_errs", 64'({skew_err, overflow_err}), 64'd0);
    rst = 1'b1;
    tick();

    // Single-row jobs from the vector table.
    for (int i = 0; i < 8; i++) begin
      start_job(vecs[i].size, 16'd1);
      out_row_ready = 1'b1;
      rd[0] = vecs[i].data;
      rv[0] = vecs[i].vld;
      exp_q.push_back(vecs[i].exp_row);
      play_rows(1, 1);
      wait_done($sformatf("vec%0d", i), 1);
      check($sformatf("vec%0d_skew", i), 64'(skew_err), 64'(vecs[i].exp_skew));
      check($sformatf("vec%0d_queue_empty", i), 64'(exp_q.size()), 64'd0);
    end

    // Two skewed rows, valid timing, and an ignored cfg_start while busy.
    start_job(16'd4, 16'd2);
    out_row_ready = 1'b0;
    rd[0] = 64'h0004_0003_0002_0001; rv[0] = 4'hF;
    rd[1] = 64'h0008_0007_0006_0005; rv[1] = 4'hF;
    exp_q.push_back(rd[0]);
    exp_q.push_back(rd[1]);
    play_rows(2, 1);
    check("seq1_valid_before_write", 64'(valid_trace[3]), 64'd0);
    check("seq1_valid_after_write", 64'(valid_trace[4]), 64'd1);
    cfg_row_count_in = 16'd5;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("seq1_busy_drain", 64'(busy), 64'd1);
    out_row_ready = 1'b1;
    wait_done("seq1", 1);
    check("seq1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Overflow: 10 rows into 8 slots with the consumer stalled.
    start_job(16'd4, 16'd10);
    expect_last = 1'b0;
    out_row_ready = 1'b0;
    for (int r = 0; r < 10; r++) begin
      rd[r] = {$urandom, $urandom};
      rv[r] = 4'hF;
      if (r < 8) exp_q.push_back(rd[r]);
    end
    play_rows(10, 1);
    check("ovf_flag", 64'(overflow_err), 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    check("ovf_skew", 64'(skew_err), 64'd0);
    out_row_ready = 1'b1;
    wait_done("ovf", 2);
    check("ovf_pops", 64'(pop_idx), 64'd8);
    check("ovf_queue_empty", 64'(exp_q.size()), 64'd0);

    // Full FIFO with a pop and a write in the same cycle.
    start_job(16'd4, 16'd9);
    out_row_ready = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rd[r] = {$urandom, $urandom};
      rv[r] = 4'hF;
      exp_q.push_back(rd[r]);
    end
    play_rows(8, 1);
    rd[0] = 64'h0909_0909_0909_0909;
    rv[0] = 4'hF;
    exp_q.push_back(rd[0]);
    ready_hook = N - 1;
    play_rows(1, 1);
    ready_hook = -1;
    out_row_ready = 1'b0;
    check("simul_no_overflow", 64'(overflow_err), 64'd0);
    check("simul_busy", 64'(busy), 64'd1);
    out_row_ready = 1'b1;
    wait_done("simul", 1);
    check("simul_pops", 64'(pop_idx), 64'd9);

    // Asynchronous reset in the middle of DRAIN.
    start_job(16'd4, 16'd3);
    out_row_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rd[r] = {$urandom, $urandom};
      rv[r] = 4'hF;
      exp_q.push_back(rd[r]);
    end
    play_rows(3, 1);
    tick();
    check("rstmid_valid_before", 64'(out_row_valid), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check("rstmid_valid_async", 64'(out_row_valid), 64'd0);
    check("rstmid_busy_async", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("rstmid_idle", 64'(busy), 64'd0);
    start_job(16'd2, 16'd2);
    out_row_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rd[r] = {$urandom, $urandom};
      rv[r] = 4'hF;
      exp_q.push_back(model_row(rd[r], 2));
    end
    play_rows(2, 2);
    wait_done("rstmid_job", 1);
    check("rstmid_errs", 64'({skew_err, overflow_err}), 64'd0);

    // Zero-row job finishes straight away.
    start_job(16'd4, 16'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_clear", 64'(done), 64'd0);
    check("zero_no_rows", 64'(pop_idx), 64'd0);

    // Randomized jobs against the row-queue model.
    for (int it = 0; it < 12; it++) begin
      int size;
      int rows;
      int gap;
      size = $urandom_range(0, 5);
      rows = $urandom_range(1, 8);
      gap  = $urandom_range(1, 3);
      start_job(16'(size), 16'(rows));
      for (int r = 0; r < rows; r++) begin
        logic [3:0] en;
        en = '0;
        for (int j = 0; j < N; j++) en[j] = (j < size);
        rd[r] = {$urandom, $urandom};
        rv[r] = 4'($urandom) | en | 4'b0001;
        exp_q.push_back(model_row(rd[r], size));
      end
      ready_rand = 1'b1;
      play_rows(rows, gap);
      wait_done($sformatf("rand%0d", it), 1);
      ready_rand = 1'b0;
      check($sformatf("rand%0d_errs", it), 64'({skew_err, overflow_err}), 64'd0);
      check($sformatf("rand%0d_queue_empty", it), 64'(exp_q.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
